circle_ring_renderer: RTL and testbench
=======================================

// Module: circle_ring_renderer
// PURPOSE
//  Consumer of the bouncing-centre coordinates (Centre_X/Centre_Y) from the movement block. Per active
//  pixel, decides whether the pixel is inside the disc, on the ring, or outside it, then drives 4:4:4
//  RGB plus aligned DE/HS/VS. Centre is sampled once per frame so the circle never tears mid-frame.
//  Sits between the VGA sync generator and the HDMI/VGA output stage.
// PARAMETERS
//  RADIUS        150  inner ring radius in pixels
//  LINE_W        3    ring thickness in pixels; ring covers RADIUS <= d < RADIUS+LINE_W
//  W_BITS        10   width of pixel and centre coordinates
//  COLOR_FRAMES  32   frames per ring-colour step (>=1)
// PORTS
//  clk          in   1       pixel clock
//  rst_n        in   1       asynchronous, active-low reset
//  pix_x        in   W_BITS  current pixel column, valid when pix_de=1
//  pix_y        in   W_BITS  current pixel row, valid when pix_de=1
//  pix_de       in   1       active-video flag
//  hs_in        in   1       horizontal sync, passed through
//  vs_in        in   1       vertical sync, passed through
//  frame_start  in   1       one-cycle pulse in vertical blanking
//  centre_x     in   W_BITS  circle centre X (free-running from movement block)
//  centre_y     in   W_BITS  circle centre Y
//  bg_data      in   12      background pixel {R,G,B}, aligned with pix_x/pix_y
//  mode         in   2       00 ring over bg, 01 filled disc over bg, 10 ring on black, 11 bg only
//  rgb_r/g/b    out  4 each  output colour
//  out_de       out  1       pix_de delayed 3 cycles
//  out_hs       out  1       hs_in delayed 3 cycles
//  out_vs       out  1       vs_in delayed 3 cycles
// BEHAVIOUR
//  - Reset: all outputs 0; pipeline flushed; latched centre = (RADIUS+LINE_W, RADIUS+LINE_W);
//    colour state RED; frame counter 0.
//  - Centre latch: cx_l/cy_l load centre_x/centre_y on the cycle frame_start=1. The new value
//    applies to any pixel entering S1 on the following cycle. Centre changes between pulses are
//    ignored.
//  - Pipeline: fixed 3-cycle latency, no stalls. pix_de/hs/vs/bg_data/mode travel in lockstep.
//    S1: adx=|pix_x-cx_l|, ady=|pix_y-cy_l|. Compute the difference signed in W_BITS+1 bits;
//        the magnitude is W_BITS bits.
//    S2: d2 = adx*adx + ady*ady, unsigned 2*W_BITS+1 bits, no truncation.
//    S3: in_disc = d2 < R2, where R2 = RADIUS^2.
//        on_ring = (d2 >= R2) && (d2 < RO2), where RO2 = (RADIUS+LINE_W)^2.
//        R2/RO2 are elaboration constants.
//  - Output mux in S3, applied when the delayed de=1:
//      mode 00: on_ring ? ring_col : bg
//      mode 01: (in_disc|on_ring) ? ring_col : bg
//      mode 10: on_ring ? ring_col : 0
//      mode 11: bg
//    When the delayed de=0, RGB is forced to 0.
//  - Colour FSM:
//    - States RED(F00) -> GREEN(0F0) -> BLUE(00F) -> WHITE(FFF) -> RED.
//    - Frame counter increments on each frame_start. On reaching COLOR_FRAMES-1 with
//      frame_start=1, it wraps to 0 and the FSM advances one state.
//    - ring_col changes only at frame_start, never mid-frame.
//  - A frame_start coincident with pix_de=1 is legal: latch and colour step still occur;
//    in-flight pixels (S1..S3) keep the old centre and colour. The colour is registered
//    into the pipeline at S1.
//  - Centre near the edges: the abs-difference handles pix_x < cx_l with no wrap. The squares of
//    the max value (2^W_BITS-1) fit without overflow.
//  - Reset asserted mid-frame: outputs go to 0 immediately (async). Rendering restarts with the
//    first pix_de after release; the centre is the reset default until the next frame_start.
// TESTING
//  1 Reset, then hold pix_de=0 -> RGB/out_de/hs/vs all 0; pulse frame_start with centre (320,240)
//    -> latched centre (320,240).
//  2 mode=00, centre (320,240), pixel (470,240) (d=150) -> 3 cycles later RGB=F00;
//    pixel (473,240) (d=153) -> RGB=bg_data; pixel (472,240) -> F00.
//  3 mode=01 pixel (320,240) -> F00; mode=10 pixel (0,0) -> 000; mode=11 pixel (470,240)
//    -> bg_data unchanged.
//  4 Change centre_x to 100 mid-frame without frame_start -> pixel (470,240) still ring;
//    after frame_start, pixel (250,240) ring and (470,240) bg.
//  5 Issue 32 frame_start pulses -> ring colour RED->GREEN exactly on pulse 32;
//    after 128 pulses back to RED.
//  6 Assert rst_n low during an active line -> outputs 0 same cycle; after release, centre
//    = (153,153), pixel (303,153) renders ring F00.

Source files
------------

// File: rtl/circle_ring_renderer.sv
// Per-pixel disc/ring classifier with a 3-stage pipeline, a once-per-frame centre latch
// and a ring colour that steps RED->GREEN->BLUE->WHITE every COLOR_FRAMES frames.
module circle_ring_renderer #(
  parameter int RADIUS       = 150,
  parameter int LINE_W       = 3,
  parameter int W_BITS       = 10,
  parameter int COLOR_FRAMES = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [W_BITS-1:0] pix_x,
  input  logic [W_BITS-1:0] pix_y,
  input  logic              pix_de,
  input  logic              hs_in,
  input  logic              vs_in,
  input  logic              frame_start,
  input  logic [W_BITS-1:0] centre_x,
  input  logic [W_BITS-1:0] centre_y,
  input  logic [11:0]       bg_data,
  input  logic [1:0]        mode,
  output logic [3:0]        rgb_r,
  output logic [3:0]        rgb_g,
  output logic [3:0]        rgb_b,
  output logic              out_de,
  output logic              out_hs,
  output logic              out_vs
);

  localparam int D2_W  = 2 * W_BITS + 1;
  localparam int CNT_W = (COLOR_FRAMES > 1) ? $clog2(COLOR_FRAMES) : 1;

  localparam logic [D2_W-1:0]   R2       = D2_W'(RADIUS * RADIUS);
  localparam logic [D2_W-1:0]   RO2      = D2_W'((RADIUS + LINE_W) * (RADIUS + LINE_W));
  localparam logic [W_BITS-1:0] C_RST    = W_BITS'(RADIUS + LINE_W);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(COLOR_FRAMES - 1);

  localparam logic [1:0] ST_RED   = 2'd0;
  localparam logic [1:0] ST_GREEN = 2'd1;
  localparam logic [1:0] ST_BLUE  = 2'd2;
  localparam logic [1:0] ST_WHITE = 2'd3;

  function automatic logic [W_BITS-1:0] abs_diff(input logic [W_BITS-1:0] a,
                                                 input logic [W_BITS-1:0] b);
    logic signed [W_BITS:0] d;
    logic signed [W_BITS:0] m;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    m = d[W_BITS] ? -d : d;
    return m[W_BITS-1:0];
  endfunction

  function automatic logic [D2_W-1:0] square(input logic [W_BITS-1:0] v);
    logic [D2_W-1:0] e;
    e = D2_W'(v);
    return e * e;
  endfunction

  function automatic logic [1:0] next_colour(input logic [1:0] st);
    case (st)
      ST_RED:   return ST_GREEN;
      ST_GREEN: return ST_BLUE;
      ST_BLUE:  return ST_WHITE;
      default:  return ST_RED;
    endcase
  endfunction

  function automatic logic [11:0] colour_rgb(input logic [1:0] st);
    case (st)
      ST_RED:   return 12'hF00;
      ST_GREEN: return 12'h0F0;
      ST_BLUE:  return 12'h00F;
      default:  return 12'hFFF;
    endcase
  endfunction

  function automatic logic [11:0] pick_colour(input logic [1:0]  md,
                                              input logic        in_disc,
                                              input logic        on_ring,
                                              input logic [11:0] col,
                                              input logic [11:0] bg);
    case (md)
      2'b00:   return on_ring ? col : bg;
      2'b01:   return (in_disc || on_ring) ? col : bg;
      2'b10:   return on_ring ? col : 12'h000;
      default: return bg;
    endcase
  endfunction

  logic [W_BITS-1:0] r_cx_l;
  logic [W_BITS-1:0] r_cy_l;
  logic [CNT_W-1:0]  r_frame_cnt;
  logic [1:0]        r_col_st;

  logic              r_vld_p0, r_hs_p0, r_vs_p0;
  logic [W_BITS-1:0] r_adx_p0, r_ady_p0;
  logic [11:0]       r_bg_p0, r_col_p0;
  logic [1:0]        r_mode_p0;

  logic              r_vld_p1, r_hs_p1, r_vs_p1;
  logic [D2_W-1:0]   r_d2_p1;
  logic [11:0]       r_bg_p1, r_col_p1;
  logic [1:0]        r_mode_p1;

  logic              r_vld_p2, r_hs_p2, r_vs_p2;
  logic [11:0]       r_rgb_p2;

  logic              w_in_disc, w_on_ring;
  logic [11:0]       w_rgb;

  // Centre and colour only move on frame_start, so a frame never renders with mixed state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cx_l      <= C_RST;
      r_cy_l      <= C_RST;
      r_frame_cnt <= '0;
      r_col_st    <= ST_RED;
    end else if (frame_start) begin
      r_cx_l <= centre_x;
      r_cy_l <= centre_y;
      if (r_frame_cnt == CNT_LAST) begin
        r_frame_cnt <= '0;
        r_col_st    <= next_colour(r_col_st);
      end else begin
        r_frame_cnt <= r_frame_cnt + 1'b1;
      end
    end
  end

  assign w_in_disc = (r_d2_p1 < R2);
  assign w_on_ring = (r_d2_p1 >= R2) && (r_d2_p1 < RO2);
  assign w_rgb     = r_vld_p1 ? pick_colour(r_mode_p1, w_in_disc, w_on_ring, r_col_p1, r_bg_p1)
                              : 12'h000;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p0 <= 1'b0;
      r_hs_p0  <= 1'b0;
      r_vs_p0  <= 1'b0;
      r_vld_p1 <= 1'b0;
      r_hs_p1  <= 1'b0;
      r_vs_p1  <= 1'b0;
      r_vld_p2 <= 1'b0;
      r_hs_p2  <= 1'b0;
      r_vs_p2  <= 1'b0;
      r_rgb_p2 <= 12'h000;
    end else begin
      r_vld_p0 <= pix_de;
      r_hs_p0  <= hs_in;
      r_vs_p0  <= vs_in;
      r_vld_p1 <= r_vld_p0;
      r_hs_p1  <= r_hs_p0;
      r_vs_p1  <= r_vs_p0;
      r_vld_p2 <= r_vld_p1;
      r_hs_p2  <= r_hs_p1;
      r_vs_p2  <= r_vs_p1;
      r_rgb_p2 <= w_rgb;
    end
  end

  always_ff @(posedge clk) begin
    // S1: distance components; colour is captured here so in-flight pixels keep it
    r_adx_p0  <= abs_diff(pix_x, r_cx_l);
    r_ady_p0  <= abs_diff(pix_y, r_cy_l);
    r_bg_p0   <= bg_data;
    r_mode_p0 <= mode;
    r_col_p0  <= colour_rgb(r_col_st);
    // S2: squared distance, full width
    r_d2_p1   <= square(r_adx_p0) + square(r_ady_p0);
    r_bg_p1   <= r_bg_p0;
    r_mode_p1 <= r_mode_p0;
    r_col_p1  <= r_col_p0;
  end

  assign rgb_r  = r_rgb_p2[11:8];
  assign rgb_g  = r_rgb_p2[7:4];
  assign rgb_b  = r_rgb_p2[3:0];
  assign out_de = r_vld_p2;
  assign out_hs = r_hs_p2;
  assign out_vs = r_vs_p2;

endmodule

// File: tb/tb_circle_ring_renderer.sv
// Scoreboard bench for circle_ring_renderer: directed pixels push expected output and due cycle,
// a negedge monitor pops and compares whenever out_de is high.
module tb_circle_ring_renderer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] pix_x, pix_y, centre_x, centre_y;
  logic       pix_de, hs_in, vs_in, frame_start;
  logic [11:0] bg_data;
  logic [1:0] mode;
  logic [3:0] rgb_r, rgb_g, rgb_b;
  logic       out_de, out_hs, out_vs;

  typedef struct packed {
    logic [15:0] id;
    logic [31:0] due;
    logic        hs;
    logic        vs;
    logic [11:0] rgb;
  } exp_t;

  exp_t sb_q[$];
  int   cyc    = 0;
  int   n_cmp  = 0;
  int   n_err  = 0;
  int   vec_id = 0;
  logic idle_req = 1'b0;
  logic end_chk  = 1'b0;

  circle_ring_renderer dut (
    .clk(clk), .rst_n(rst_n),
    .pix_x(pix_x), .pix_y(pix_y), .pix_de(pix_de),
    .hs_in(hs_in), .vs_in(vs_in), .frame_start(frame_start),
    .centre_x(centre_x), .centre_y(centre_y),
    .bg_data(bg_data), .mode(mode),
    .rgb_r(rgb_r), .rgb_g(rgb_g), .rgb_b(rgb_b),
    .out_de(out_de), .out_hs(out_hs), .out_vs(out_vs)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor
  always @(negedge clk) begin
    if (end_chk) begin
      n_cmp <= n_cmp + 1;
      if (sb_q.size() != 0) begin
        n_err <= n_err + 1;
        $display("FAIL drain: %0d expected pixels never appeared, required 0", sb_q.size());
      end
    end else if (idle_req) begin
      n_cmp <= n_cmp + 1;
      if ({out_de, out_hs, out_vs, rgb_r, rgb_g, rgb_b} != 15'd0) begin
        n_err <= n_err + 1;
        $display("FAIL idle@%0d: de/hs/vs/rgb=%b/%b/%b/%h%h%h, required all 0",
                 cyc, out_de, out_hs, out_vs, rgb_r, rgb_g, rgb_b);
      end
    end else if (out_de) begin
      n_cmp <= n_cmp + 1;
      if (sb_q.size() == 0) begin
        n_err <= n_err + 1;
        $display("FAIL unexpected@%0d: out_de=1 rgb=%h%h%h, required no output",
                 cyc, rgb_r, rgb_g, rgb_b);
      end else begin
        if ({out_hs, out_vs, rgb_r, rgb_g, rgb_b} != {sb_q[0].hs, sb_q[0].vs, sb_q[0].rgb} ||
            sb_q[0].due != 32'(cyc)) begin
          n_err <= n_err + 1;
          $display("FAIL pix%0d: got hs/vs/rgb=%b/%b/%h%h%h at cycle %0d, required %b/%b/%h at cycle %0d",
                   sb_q[0].id, out_hs, out_vs, rgb_r, rgb_g, rgb_b, cyc,
                   sb_q[0].hs, sb_q[0].vs, sb_q[0].rgb, sb_q[0].due);
        end
        sb_q.delete(0);
      end
    end
  end

  task automatic drv(input logic [9:0] x, input logic [9:0] y, input logic de,
                     input logic hs, input logic vs, input logic fs,
                     input logic [11:0] bg, input logic [1:0] md);
    @(posedge clk); #1;
    pix_x = x; pix_y = y; pix_de = de; hs_in = hs; vs_in = vs;
    frame_start = fs; bg_data = bg; mode = md; idle_req = 1'b0;
  endtask

  task automatic pix(input logic [9:0] x, input logic [9:0] y, input logic [1:0] md,
                     input logic [11:0] bg, input logic [1:0] sync, input logic fs,
                     input logic [11:0] exp_rgb);
    exp_t e;
    drv(x, y, 1'b1, sync[1], sync[0], fs, bg, md);
    e.id  = 16'(vec_id);
    e.due = 32'(cyc + 3);
    e.hs  = sync[1];
    e.vs  = sync[0];
    e.rgb = exp_rgb;
    sb_q.push_back(e);
    vec_id++;
  endtask

  task automatic quiet(input int n, input logic chk);
    repeat (n) begin
      drv(10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 12'hFFF, 2'b11);
      idle_req = chk;
    end
  endtask

  task automatic fs_pulse(input logic [9:0] cx, input logic [9:0] cy);
    centre_x = cx;
    centre_y = cy;
    drv(10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b1, 12'h000, 2'b00);
    drv(10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 2'b00);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; pix_de = 1'b0; hs_in = 1'b0; vs_in = 1'b0; frame_start = 1'b0;
    idle_req = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    quiet(3, 1'b1);
  endtask

  function automatic logic [11:0] ring_after(input int pulses);
    case ((pulses / 32) % 4)
      0:       return 12'hF00;
      1:       return 12'h0F0;
      2:       return 12'h00F;
      default: return 12'hFFF;
    endcase
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1; pix_x = '0; pix_y = '0; pix_de = 1'b0; hs_in = 1'b0; vs_in = 1'b0;
    frame_start = 1'b0; centre_x = '0; centre_y = '0; bg_data = '0; mode = 2'b00;
    #2 rst_n = 1'b0;
    #1 idle_req = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    // Test 1: idle after reset, de=0 forces RGB to 0 even with bg present
    quiet(5, 1'b1);
    fs_pulse(10'd320, 10'd240);

    // Test 2: ring boundaries on both sides of the centre
    pix(10'd470, 10'd240, 2'b00, 12'h3A5, 2'b00, 1'b0, 12'hF00);
    pix(10'd473, 10'd240, 2'b00, 12'h3A5, 2'b10, 1'b0, 12'h3A5);
    pix(10'd472, 10'd240, 2'b00, 12'h3A5, 2'b01, 1'b0, 12'hF00);
    pix(10'd170, 10'd240, 2'b00, 12'h456, 2'b11, 1'b0, 12'hF00);
    pix(10'd167, 10'd240, 2'b00, 12'h456, 2'b00, 1'b0, 12'h456);
    pix(10'd426, 10'd346, 2'b00, 12'h789, 2'b00, 1'b0, 12'h789);

    // Test 3: modes
    pix(10'd320, 10'd240, 2'b01, 12'h111, 2'b00, 1'b0, 12'hF00);
    pix(10'd426, 10'd346, 2'b01, 12'h111, 2'b00, 1'b0, 12'hF00);
    pix(10'd0,   10'd0,   2'b10, 12'h222, 2'b00, 1'b0, 12'h000);
    pix(10'd470, 10'd240, 2'b10, 12'h222, 2'b00, 1'b0, 12'hF00);
    pix(10'd426, 10'd346, 2'b10, 12'h222, 2'b00, 1'b0, 12'h000);
    pix(10'd470, 10'd240, 2'b11, 12'hABC, 2'b00, 1'b0, 12'hABC);
    quiet(4, 1'b0);
    quiet(3, 1'b1);

    // Test 4: centre changes only on frame_start; coincident pixel keeps the old centre
    centre_x = 10'd100;
    pix(10'd470, 10'd240, 2'b00, 12'h0AA, 2'b00, 1'b0, 12'hF00);
    pix(10'd470, 10'd240, 2'b00, 12'h0AA, 2'b00, 1'b1, 12'hF00);
    pix(10'd470, 10'd240, 2'b00, 12'h0AA, 2'b00, 1'b0, 12'h0AA);
    pix(10'd250, 10'd240, 2'b00, 12'h0AA, 2'b00, 1'b0, 12'hF00);
    quiet(4, 1'b0);

    // Edge centres: no wrap on abs difference, no overflow on max squares
    fs_pulse(10'd0, 10'd0);
    pix(10'd1023, 10'd1023, 2'b01, 12'h5A5, 2'b00, 1'b0, 12'h5A5);
    pix(10'd150,  10'd0,    2'b00, 12'h5A5, 2'b00, 1'b0, 12'hF00);
    pix(10'd0,    10'd152,  2'b10, 12'h5A5, 2'b00, 1'b0, 12'hF00);
    pix(10'd0,    10'd153,  2'b10, 12'h5A5, 2'b00, 1'b0, 12'h000);
    fs_pulse(10'd1023, 10'd1023);
    pix(10'd873,  10'd1023, 2'b00, 12'h0C3, 2'b00, 1'b0, 12'hF00);
    pix(10'd1023, 10'd870,  2'b00, 12'h0C3, 2'b00, 1'b0, 12'h0C3);
    pix(10'd0,    10'd0,    2'b01, 12'h0C3, 2'b00, 1'b0, 12'h0C3);
    quiet(4, 1'b0);

    // Test 5: colour stepping from a fresh reset
    do_reset();
    for (int k = 1; k <= 128; k++) begin
      fs_pulse(10'd320, 10'd240);
      if (k == 31 || k == 32 || k == 63 || k == 64 || k == 96 || k == 128)
        pix(10'd470, 10'd240, (k == 64) ? 2'b10 : 2'b00, 12'h123, 2'b00, 1'b0, ring_after(k));
    end
    quiet(4, 1'b0);

    // Test 6: async reset in the middle of an active line
    pix(10'd470, 10'd240, 2'b00, 12'h0F0, 2'b00, 1'b0, 12'hF00);
    pix(10'd471, 10'd240, 2'b00, 12'h0F0, 2'b00, 1'b0, 12'hF00);
    pix(10'd472, 10'd240, 2'b00, 12'h0F0, 2'b00, 1'b0, 12'hF00);
    @(posedge clk); #1;
    rst_n = 1'b0;
    idle_req = 1'b1;
    sb_q.delete();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    pix_de = 1'b0;
    quiet(3, 1'b1);
    pix(10'd303, 10'd153, 2'b00, 12'h0F0, 2'b00, 1'b0, 12'hF00);
    pix(10'd153, 10'd153, 2'b01, 12'h0F0, 2'b00, 1'b0, 12'hF00);
    pix(10'd456, 10'd153, 2'b00, 12'h0F0, 2'b00, 1'b0, 12'h0F0);
    quiet(5, 1'b0);

    @(posedge clk); #1 end_chk = 1'b1;
    @(posedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
